// File: rtl/player_input_arbiter.sv
// Purpose: synchronizes and debounces four player buttons, then latches the first press and the answer switches.
// Latency: a held raw press raises playerInputFlag DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: a capture stays pending until ack; re-arm waits until every debounced button is low.
// Optional build macro PLAYER_INPUT_ROUND_ROBIN_EN: rotating tie-break starting after the previous winner.
module player_input_arbiter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [7:0] sw,
    input  logic       en,
    input  logic       ack,
    output logic       playerInputFlag,
    output logic [1:0] firstPlayerFlag,
    output logic [7:0] switchInput
);

    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CAPTURED = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          capture;
    logic [3:0]    btn_s1;
    logic [3:0]    btn_s2;
    logic [7:0]    sw_s1;
    logic [7:0]    sw_s2;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [CW-1:0] cnt [4];
    logic [3:0]    press;
    logic [1:0]    win;
`ifdef PLAYER_INPUT_ROUND_ROBIN_EN
    logic [1:0]    last_win;
    logic [1:0]    start;
    logic [1:0]    idx;
`endif

    // Two-flop synchronizers; only the second stage feeds any logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    // Per-button debouncer: flip the level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press event is a rising edge of the debounced level, alive for one cycle.
    assign press = deb & ~deb_q;

`ifdef PLAYER_INPUT_ROUND_ROBIN_EN
    // Rotating pick: scan from last_win+1 upward with wrap; descending loop lets the nearest one win.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        start = last_win + 2'd1;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (press[idx]) begin
                win = idx;
            end
        end
    end

    // Remember who won last so the next tie starts just after them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_win <= 2'd3;
        end else if (capture) begin
            last_win <= win;
        end
    end
`else
    // Fixed pick: lowest index among simultaneous presses.
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (press[k]) begin
                win = 2'(k);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: capture on an enabled press, release on ack, re-arm once all buttons are up.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ARMED: begin
                if (en && (|press)) begin
                    state_nxt = CAPTURED;
                    capture   = 1'b1;
                end
            end
            CAPTURED: begin
                if (ack) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (deb == 4'b0000) begin
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = ARMED;
        endcase
    end

    // Registered outputs; the flag mirrors CAPTURED so it carries no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            playerInputFlag <= 1'b0;
            firstPlayerFlag <= 2'd0;
            switchInput     <= 8'd0;
        end else begin
            playerInputFlag <= (state_nxt == CAPTURED);
            if (capture) begin
                firstPlayerFlag <= win;
                switchInput     <= sw_s2;
            end
        end
    end

endmodule

// File: tb/tb_player_input_arbiter.sv
// Purpose: self-checking bench for player_input_arbiter with DEBOUNCE_CYCLES=4.
// Latency: expected captures are queued at stimulus time and compared when playerInputFlag rises.
// Backpressure: ack is pulsed by the bench; release/re-arm is checked through blocked captures.
module tb_player_input_arbiter;

    localparam int DB = 4;

    typedef struct {
        logic [1:0] player;
        logic [7:0] swv;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [7:0] sw;
    logic       en;
    logic       ack;
    logic       playerInputFlag;
    logic [1:0] firstPlayerFlag;
    logic [7:0] switchInput;

    int   n_chk;
    int   n_fail;
    exp_t sb_q[$];
    logic [1:0] tie_exp;

    player_input_arbiter #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn             (btn),
        .sw              (sw),
        .en              (en),
        .ack             (ack),
        .playerInputFlag (playerInputFlag),
        .firstPlayerFlag (firstPlayerFlag),
        .switchInput     (switchInput)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; returns at the falling edge after the last rising edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] p, input logic [7:0] s);
        exp_t e;
        e.player = p;
        e.swv    = s;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every rising flag must match the oldest queued expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (playerInputFlag && !prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {31'd0, playerInputFlag}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_player", {30'd0, firstPlayerFlag}, {30'd0, e.player});
                    chk("sb_switch", {24'd0, switchInput}, {24'd0, e.swv});
                end
            end
            prev = playerInputFlag;
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        btn = 4'h0;
        sw  = 8'h00;
        en  = 1'b0;
        ack = 1'b0;

        // Reset state.
        step(3);
        chk("rst_flag", {31'd0, playerInputFlag}, 32'd0);
        chk("rst_player", {30'd0, firstPlayerFlag}, 32'd0);
        chk("rst_switch", {24'd0, switchInput}, 32'd0);

        // Basic capture latency: btn[2] held from edge 0.
        rst = 1'b1;
        en  = 1'b1;
        sw  = 8'h3C;
        btn = 4'b0100;
        push_exp(2'd2, 8'h3C);
        step(DB + 2);
        chk("lat_early", {31'd0, playerInputFlag}, 32'd0);
        step(1);
        chk("lat_on", {31'd0, playerInputFlag}, 32'd1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("ack_flag", {31'd0, playerInputFlag}, 32'd0);
        chk("ack_keep_player", {30'd0, firstPlayerFlag}, 32'd2);
        chk("ack_keep_switch", {24'd0, switchInput}, 32'h3C);
        btn = 4'h0;
        step(10);

        // Glitch shorter than the debounce window, then a long pulse.
        btn = 4'b0010;
        step(3);
        btn = 4'h0;
        step(12);
        chk("glitch_none", {31'd0, playerInputFlag}, 32'd0);
        sw  = 8'h11;
        btn = 4'b0010;
        push_exp(2'd1, 8'h11);
        step(8);
        btn = 4'h0;
        chk("pulse8_flag", {31'd0, playerInputFlag}, 32'd1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(10);

        // Simultaneous presses of players 3 and 1 (previous winner was 1).
`ifdef PLAYER_INPUT_ROUND_ROBIN_EN
        tie_exp = 2'd3;
`else
        tie_exp = 2'd1;
`endif
        sw  = 8'h5A;
        btn = 4'b1010;
        push_exp(tie_exp, 8'h5A);
        step(DB + 3);
        chk("tie_flag", {31'd0, playerInputFlag}, 32'd1);

        // Held outputs while captured: new press, switch change, en drop.
        btn = 4'b1011;
        sw  = 8'hA5;
        en  = 1'b0;
        step(10);
        en  = 1'b1;
        chk("hold_flag", {31'd0, playerInputFlag}, 32'd1);
        chk("hold_player", {30'd0, firstPlayerFlag}, {30'd0, tie_exp});
        chk("hold_switch", {24'd0, switchInput}, 32'h5A);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("hold_ack_flag", {31'd0, playerInputFlag}, 32'd0);
        // Buttons still held: a fresh press of btn[2] must not capture from RELEASE.
        btn = 4'b1111;
        step(10);
        chk("release_block", {31'd0, playerInputFlag}, 32'd0);
        btn = 4'h0;
        step(12);

        // Press while disabled is discarded, not queued.
        en  = 1'b0;
        btn = 4'b0001;
        step(10);
        chk("en_off", {31'd0, playerInputFlag}, 32'd0);
        en = 1'b1;
        step(10);
        chk("en_held", {31'd0, playerInputFlag}, 32'd0);
        btn = 4'h0;
        step(10);
        btn = 4'b0001;
        push_exp(2'd0, 8'hA5);
        step(DB + 2);
        chk("repress_early", {31'd0, playerInputFlag}, 32'd0);
        // ack coincident with the capture edge is ignored.
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("repress_on", {31'd0, playerInputFlag}, 32'd1);
        step(2);
        chk("ack_armed_ign", {31'd0, playerInputFlag}, 32'd1);

        // Asynchronous reset in CAPTURED with btn[0] still held.
        rst = 1'b0;
        #1;
        chk("arst_flag", {31'd0, playerInputFlag}, 32'd0);
        chk("arst_player", {30'd0, firstPlayerFlag}, 32'd0);
        chk("arst_switch", {24'd0, switchInput}, 32'd0);
        step(3);
        rst = 1'b1;
        push_exp(2'd0, 8'hA5);
        step(DB + 2);
        chk("arst_relat_early", {31'd0, playerInputFlag}, 32'd0);
        step(1);
        chk("arst_relat_on", {31'd0, playerInputFlag}, 32'd1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        btn = 4'h0;
        step(10);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
